// File: rtl/burst_window_pkg.sv
// Shared types and constants for the burst window controller and its tail counter.
package burst_window_pkg;

   typedef enum logic [1:0] {IDLE, ACTIVE, TAIL} bw_state_e;

   localparam int BW_TAIL_DEFAULT = 1;
   localparam int BW_TAIL_W       = 8;

   // The done/aborted cycle is the first tail cycle, so the countdown starts one short.
   function automatic logic [BW_TAIL_W-1:0] bw_tail_reload(input int tail);
      return BW_TAIL_W'(tail - 1);
   endfunction

endpackage

// File: rtl/win_down_cnt.sv
// Loadable down-counter that parks at zero and raises a zero flag; times the hold tail.
module win_down_cnt
   import burst_window_pkg::*;
#(
   parameter int W = BW_TAIL_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] count;

   // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/burst_window_ctrl.sv
// Burst window generator: opens busy/hold on start, counts beats under stall,
// closes with a done or aborted pulse and keeps hold high for a programmable tail.
module burst_window_ctrl
   import burst_window_pkg::*;
#(
   parameter int LEN_W = 8,
   parameter int TAIL  = BW_TAIL_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             stall,
   input  logic             abort,
   output logic             ready,
   output logic             busy,
   output logic             hold,
   output logic             done,
   output logic             aborted,
   output logic [LEN_W-1:0] beat_cnt
);

   localparam logic [LEN_W-1:0]     BEAT_ONE    = LEN_W'(1);
   localparam logic [BW_TAIL_W-1:0] TAIL_RELOAD = bw_tail_reload(TAIL);

   bw_state_e        state;
   logic [LEN_W-1:0] len_q;
   logic             beat_ok;
   logic             last_beat;
   logic             win_close;
   logic             in_tail;
   logic             tail_zero;

   // Abort has priority over a beat in the same cycle, so a beat only counts without abort.
   assign beat_ok   = (state == ACTIVE) && !stall && !abort;
   assign last_beat = beat_ok && ((beat_cnt + BEAT_ONE) == len_q);
   assign win_close = (state == ACTIVE) && (abort || last_beat);
   assign in_tail   = (state == burst_window_pkg::TAIL);

   win_down_cnt #(
      .W (BW_TAIL_W)
   ) u_tail_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (win_close),
      .load_val (TAIL_RELOAD),
      .dec      (in_tail),
      .zero     (tail_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         len_q    <= '0;
         beat_cnt <= '0;
         ready    <= 1'b1;
         busy     <= 1'b0;
         hold     <= 1'b0;
         done     <= 1'b0;
         aborted  <= 1'b0;
      end else begin
         done    <= 1'b0;
         aborted <= 1'b0;
         case (state)
            IDLE: begin
               if (start && (len != '0)) begin
                  state    <= ACTIVE;
                  len_q    <= len;
                  beat_cnt <= '0;
                  ready    <= 1'b0;
                  busy     <= 1'b1;
                  hold     <= 1'b1;
               end
            end
            ACTIVE: begin
               if (abort) begin
                  state   <= burst_window_pkg::TAIL;
                  busy    <= 1'b0;
                  aborted <= 1'b1;
               end else if (beat_ok) begin
                  beat_cnt <= beat_cnt + BEAT_ONE;
                  if (last_beat) begin
                     state <= burst_window_pkg::TAIL;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
            end
            burst_window_pkg::TAIL: begin
               if (tail_zero) begin
                  state <= IDLE;
                  hold  <= 1'b0;
                  ready <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               hold  <= 1'b0;
               ready <= 1'b1;
            end
         endcase
      end
   end

endmodule
